// File: rtl/des_key_sched_rev.sv
// DES decryption key schedule: PC-1 on start, then K16..K1 via PC-2 with right rotations.
// Latency: K16 valid the cycle after start; one subkey per handshake; done pulses after K1.
module des_key_sched_rev (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] key_in,
   output logic        ready,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic [47:0] subkey,
   output logic [4:0]  round,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Tables hold FIPS 46-3 bit numbers (1 = MSB).
   localparam int PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      logic [5:0]  idx;
      r = '0;
      for (int i = 0; i < 56; i++) begin
         idx = 6'(64 - PC1_TAB[i]);
         r[55-i] = k[idx];
      end
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] c);
      logic [47:0] r;
      logic [5:0]  idx;
      r = '0;
      for (int i = 0; i < 48; i++) begin
         idx = 6'(56 - PC2_TAB[i]);
         r[47-i] = c[idx];
      end
      return r;
   endfunction

   // Each 28-bit half rotates independently; nothing crosses between C and D.
   function automatic logic [55:0] rotr(input logic [55:0] c, input logic one);
      logic [27:0] ch, dh;
      ch = c[55:28];
      dh = c[27:0];
      if (one) begin
         ch = {ch[0], ch[27:1]};
         dh = {dh[0], dh[27:1]};
      end else begin
         ch = {ch[1:0], ch[27:2]};
         dh = {dh[1:0], dh[27:2]};
      end
      return {ch, dh};
   endfunction

   state_t      state, state_nxt;
   logic [55:0] cd, cd_nxt;
   logic [4:0]  round_nxt;
   logic        shift_one;

   assign subkey       = pc2(cd);
   assign subkey_valid = (state == RUN);
   assign ready        = (state == IDLE);
   assign done         = (state == DONE);
   assign shift_one    = (round == 5'd1) || (round == 5'd2) ||
                         (round == 5'd9) || (round == 5'd16);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cd    <= '0;
         round <= '0;
      end else begin
         state <= state_nxt;
         cd    <= cd_nxt;
         round <= round_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cd_nxt    = cd;
      round_nxt = round;
      case (state)
         IDLE: begin
            if (start) begin
               cd_nxt    = pc1(key_in);
               round_nxt = 5'd16;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (subkey_ready) begin
               if (round == 5'd1) begin
                  state_nxt = DONE;
               end else begin
                  cd_nxt    = rotr(cd, shift_one);
                  round_nxt = round - 5'd1;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/des_key_sched_rev.md
Name: des_key_sched_rev

Overview:
- Sequential DES decryption key scheduler. It is the reverse-direction counterpart of the encryption key mixer.
- Accepts a 64-bit key, applies PC-1, and emits round subkeys K16 down to K1, one per accepted handshake, with each subkey formed by PC-2.
- Between subkeys, the C and D halves are rotated right, undoing the encryption left rotations.
- Feeds the decryption round datapath, which consumes one 48-bit subkey per round.

Parameters:
- None. Widths are fixed by DES: key 64, C/D 28+28, subkey 48.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request a new schedule; sampled only in IDLE
- key_in  input  64  DES key; DES bit 1 = key_in[63]; parity bits 8,16,...,64 are ignored by PC-1
- ready  output  1  high in IDLE; start is accepted only when ready=1
- subkey_valid  output  1  subkey and round are valid
- subkey_ready  input  1  consumer accepts the subkey when subkey_valid&&subkey_ready
- subkey  output  48  PC-2 of the current C/D; DES bit 1 = subkey[47]
- round  output  5  round index of subkey, counting 16 down to 1
- done  output  1  one-cycle pulse after K1 is accepted

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-schedule):
  - state=IDLE; cd=0; round=0; done=0.
  - Hence subkey_valid=0 and ready=1 in the first cycle after reset.
  - A partially delivered schedule is abandoned; no done pulse.
- Registers: cd[55:0] = {C[27:0], D[27:0]}, round[4:0], state.
- Outputs are derived from registers only:
  - subkey = PC2(cd), pure wiring.
  - subkey_valid = (state==RUN).
  - ready = (state==IDLE).
  - No combinational path from any input to any output.
- FSM:
  - IDLE: if start, then cd<=PC1(key_in), round<=16, go to RUN. Otherwise hold. key_in is sampled only on this edge.
  - RUN, handshake with round>1: C<=rotr(C,s), D<=rotr(D,s), round<=round-1, where s=shift(round).
  - RUN, handshake with round==1: go to DONE; cd and round hold.
  - RUN, no handshake: hold cd, round and subkey stable. A valid subkey must not change until it is accepted.
  - DONE: done=1 for exactly this cycle, then go to IDLE unconditionally. start is ignored in DONE.
- Shift table: shift(r)=1 for r in {1,2,9,16}; shift(r)=2 otherwise. Total right rotation over the run is 27 positions, so K1 corresponds to C0 rotated left by 1.
- Rotation is a true circular rotate within each 28-bit half. No bits are lost and there is no carry between C and D.
- Latency:
  - start accepted at edge N → K16 valid in cycle N+1.
  - With subkey_ready held high, K16..K1 appear on 16 consecutive cycles, done pulses the next cycle, and ready is high the cycle after that.
  - Minimum start-to-start interval: 18 cycles.
- Boundaries:
  - start while not IDLE: ignored, with no effect on an in-flight schedule.
  - start and rst together: rst wins.
  - subkey_ready while not RUN: ignored.
  - key_in changes during RUN: no effect.
- PC-1 and PC-2 tables follow FIPS 46-3 exactly.

Test Plan:
- Standard key, no stall: key_in=64'h133457799BBCDFF1, start pulse, subkey_ready=1.
  - Required: cycle+1 gives round=16, subkey=48'hCB3D8B0E17F5.
  - Next cycle: round=15, subkey=48'hBF918D3D3F0A.
  - Round 2 subkey=48'h79AED9DBC9E5; round 1 subkey=48'h1B02EFFC7072.
  - done pulses one cycle later; ready=1 the cycle after.
- Backpressure: same key, subkey_ready held 0 for 5 cycles at round 9, then toggled randomly.
  - Required: round/subkey stay stable while subkey_ready=0.
  - Exactly 16 transfers occur, in sequence 16..1, with values matching the no-stall run.
- Weak keys: key_in=64'h0101010101010101 and then 64'hFEFEFEFEFEFEFEFE.
  - Required: all 16 subkeys are 48'h000000000000 and 48'hFFFFFFFFFFFF respectively (parity bits ignored).
- Reset mid-run: assert rst at round 7.
  - Required: next cycle subkey_valid=0, ready=1, round=0, and no done pulse.
  - A fresh start then produces the full correct sequence from round 16.
- start ignored while busy: pulse start with a different key_in at round 12 and again during DONE.
  - Required: the schedule continues unchanged with the original key; ready stays 0 until after done.
- Back-to-back keys: a second start on the first cycle ready=1.
  - Required: K16 of the second key appears on the next cycle, i.e. an 18-cycle start-to-start interval.
